// File: rtl/trng_health_buffer_if.sv
// Bundles the random-source, output-stream and alarm signals of the health buffer.
// Latency: none, wiring only.
// Backpressure: carries word_ready_i from the consumer back to the buffer.
interface trng_health_buffer_if #(
  parameter int BLOCK_WIDTH = 256,
  parameter int WORD_WIDTH  = 32
);
  logic                   trng_en_o;
  logic [BLOCK_WIDTH-1:0] trng_data_i;
  logic                   trng_valid_i;
  logic [WORD_WIDTH-1:0]  word_o;
  logic                   word_valid_o;
  logic                   word_ready_i;
  logic                   clear_fail_i;
  logic                   fail_o;
  logic [1:0]             fail_code_o;
  logic [15:0]            block_cnt_o;

  // Health buffer side
  modport slave (
    output trng_en_o,
    input  trng_data_i,
    input  trng_valid_i,
    output word_o,
    output word_valid_o,
    input  word_ready_i,
    input  clear_fail_i,
    output fail_o,
    output fail_code_o,
    output block_cnt_o
  );

  // Source / consumer side
  modport master (
    input  trng_en_o,
    output trng_data_i,
    output trng_valid_i,
    input  word_o,
    input  word_valid_o,
    output word_ready_i,
    output clear_fail_i,
    input  fail_o,
    input  fail_code_o,
    input  block_cnt_o
  );
endinterface

// File: rtl/trng_health_buffer.sv
// Captures 256-bit random blocks, runs repetition and ones-proportion health tests, serves passing blocks as words.
// Latency: first word valid NUM_WORDS cycles after the capture edge; then one word per cycle.
// Backpressure: word_o holds while word_ready_i is low; the source is not re-enabled until the block is drained.
module trng_health_buffer #(
  parameter int BLOCK_WIDTH = 256,
  parameter int WORD_WIDTH  = 32,
  parameter int ONES_MIN    = 96,
  parameter int ONES_MAX    = 160
) (
  input logic clk,
  input logic rst_n,
  trng_health_buffer_if.slave bus
);
  localparam int NUM_WORDS = BLOCK_WIDTH / WORD_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int ACC_W     = $clog2(BLOCK_WIDTH) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [ACC_W-1:0] MIN_ONES = ACC_W'(ONES_MIN);
  localparam logic [ACC_W-1:0] MAX_ONES = ACC_W'(ONES_MAX);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FAIL  = 2'd3;

  logic [1:0]             r_state;
  logic [BLOCK_WIDTH-1:0] r_buf;
  logic [IDX_W-1:0]       r_idx;
  logic [ACC_W-1:0]       r_acc;
  logic                   r_rep;
  logic [WORD_WIDTH-1:0]  r_prev_word;
  logic                   r_prev_valid;
  logic [1:0]             r_fail_code;
  logic [15:0]            r_block_cnt;

  logic [IDX_W-1:0]       w_idx_m1;
  logic [WORD_WIDTH-1:0]  w_word;
  logic [WORD_WIDTH-1:0]  w_word_prev;
  logic [ACC_W-1:0]       w_pc;
  logic [ACC_W-1:0]       w_sum;
  logic                   w_eq;
  logic                   w_rep;
  logic                   w_prop;
  logic                   w_xfer;

  // Current word (checked in CHECK, served in DRAIN) and its predecessor inside the block
  assign w_idx_m1    = r_idx - IDX_W'(1);
  assign w_word      = r_buf[r_idx*WORD_WIDTH +: WORD_WIDTH];
  assign w_word_prev = r_buf[w_idx_m1*WORD_WIDTH +: WORD_WIDTH];

  // Popcount of the word under test
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      w_pc = w_pc + ACC_W'(w_word[i]);
    end
  end

  // Word 0 compares against the last word of the previous passed block, if one is remembered
  assign w_eq   = (r_idx == '0) ? (r_prev_valid && (w_word == r_prev_word))
                                : (w_word == w_word_prev);
  assign w_rep  = r_rep | w_eq;
  assign w_sum  = r_acc + w_pc;
  assign w_prop = (w_sum < MIN_ONES) || (w_sum > MAX_ONES);
  assign w_xfer = (r_state == S_DRAIN) && bus.word_ready_i;

  assign bus.trng_en_o    = (r_state == S_FILL);
  assign bus.word_valid_o = (r_state == S_DRAIN);
  assign bus.word_o       = (r_state == S_DRAIN) ? w_word : '0;
  assign bus.fail_o       = (r_state == S_FAIL);
  assign bus.fail_code_o  = r_fail_code;
  assign bus.block_cnt_o  = r_block_cnt;

  // Capture / check / drain / alarm sequencing with all health-test state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_buf        <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_rep        <= 1'b0;
      r_prev_word  <= '0;
      r_prev_valid <= 1'b0;
      r_fail_code  <= 2'b00;
      r_block_cnt  <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (bus.trng_valid_i) begin
            r_buf   <= bus.trng_data_i;
            r_acc   <= '0;
            r_idx   <= '0;
            r_rep   <= 1'b0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_acc <= w_sum;
          r_rep <= w_rep;
          if (r_idx == LAST_IDX) begin
            r_idx <= '0;
            if (w_rep || w_prop) begin
              r_fail_code <= {w_prop, w_rep};
              r_state     <= S_FAIL;
            end else begin
              if (r_block_cnt != 16'hFFFF) begin
                r_block_cnt <= r_block_cnt + 16'd1;
              end
              r_prev_word  <= w_word;
              r_prev_valid <= 1'b1;
              r_state      <= S_DRAIN;
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= S_FILL;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          if (bus.clear_fail_i) begin
            r_fail_code  <= 2'b00;
            r_prev_valid <= 1'b0;
            r_state      <= S_FILL;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trng_health_buffer.sv
// Self-checking bench for trng_health_buffer: table of blocks plus stall, cross-block repetition and reset sequences.
// Latency: checks valid rising exactly NUM_WORDS cycles after capture.
// Backpressure: drives ready high or in a 1,0,0,1 pattern and checks word hold and order.
module tb_trng_health_buffer;
  localparam int BW = 256;
  localparam int WW = 32;
  localparam int NW = BW / WW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trng_health_buffer_if #(.BLOCK_WIDTH(BW), .WORD_WIDTH(WW)) bus ();

  trng_health_buffer #(
    .BLOCK_WIDTH(BW), .WORD_WIDTH(WW), .ONES_MIN(96), .ONES_MAX(160)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [BW-1:0] blk;
    logic          pass;
    logic [1:0]    code;
    logic [15:0]   cnt;
    string         name;
  } vec_t;

  vec_t            tbl[4];
  int              checks = 0;
  int              errors = 0;
  logic [WW-1:0]   exp_q[$];
  int              xfer_cnt = 0;
  logic            held_vld = 1'b0;
  logic [WW-1:0]   held_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Block patterns, word k at bits [k*WW +: WW]
  function automatic logic [BW-1:0] build(input int kind);
    logic [BW-1:0] b;
    logic [WW-1:0] w;
    logic [WW-1:0] kk;
    b = '0;
    for (int k = 0; k < NW; k++) begin
      kk = WW'(k);
      case (kind)
        0:       w = 32'h0F0F0F0F ^ ((kk << 28) | kk);   // distinct, 16 ones each
        1:       w = 32'hA5A5A5A5;                      // repeated words
        2:       w = '0;                                // repeated, sum 0
        3:       w = kk + 32'd1;                        // distinct, sum 13
        4:       w = 32'h33333333 ^ ((kk << 28) | kk);  // distinct, sum 120, last word 0x43333334
        default: w = (k == 0) ? 32'h43333334 : (32'h0F0F0F0F ^ ((kk << 28) | kk)); // sum 126
      endcase
      b[k*WW +: WW] = w;
    end
    return b;
  endfunction

  // Scoreboard consumer: pops one expected word per transfer, checks hold during stalls
  always @(negedge clk) begin
    if (rst_n && bus.word_valid_o) begin
      if (held_vld) check("stall_hold", bus.word_o, held_word);
      if (bus.word_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("word_order", bus.word_o, exp_q.pop_front());
        end
        xfer_cnt++;
        held_vld = 1'b0;
      end else begin
        held_vld  = 1'b1;
        held_word = bus.word_o;
      end
    end else begin
      held_vld = 1'b0;
    end
  end

  task automatic wait_en();
    int n = 0;
    while (bus.trng_en_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("en_before_capture", bus.trng_en_o, 1);
  endtask

  task automatic send_block(input logic [BW-1:0] blk, input logic pass);
    wait_en();
    bus.trng_data_i  = blk;
    bus.trng_valid_i = 1'b1;
    if (pass) for (int k = 0; k < NW; k++) exp_q.push_back(blk[k*WW +: WW]);
    @(posedge clk); #1;
    bus.trng_valid_i = 1'b0;
    bus.trng_data_i  = ~blk;
  endtask

  task automatic wait_result(input logic pass, input logic [1:0] code, input logic [15:0] cnt,
                             input string nm);
    int bad = 0;
    for (int k = 1; k < NW; k++) begin
      @(posedge clk); #1;
      if (bus.word_valid_o !== 1'b0 || bus.fail_o !== 1'b0 || bus.trng_en_o !== 1'b0) bad++;
    end
    check({nm, " quiet_in_check"}, bad, 0);
    @(posedge clk); #1;
    check({nm, " valid_at_8"}, bus.word_valid_o, pass);
    check({nm, " fail_o"}, bus.fail_o, !pass);
    check({nm, " fail_code"}, bus.fail_code_o, code);
    check({nm, " block_cnt"}, bus.block_cnt_o, cnt);
    if (!pass) check({nm, " en_low_in_fail"}, bus.trng_en_o, 0);
  endtask

  task automatic drain(input bit toggle);
    int c = 0;
    logic [3:0] pat = 4'b1001;
    while (c < 100) begin
      bus.word_ready_i = toggle ? pat[c % 4] : 1'b1;
      @(posedge clk); #1;
      c++;
      if (bus.trng_en_o === 1'b1) break;
    end
    bus.word_ready_i = 1'b1;
    check("drain_transfers", xfer_cnt, 8);
    check("drain_queue_empty", exp_q.size(), 0);
    xfer_cnt = 0;
  endtask

  task automatic clear_seq();
    @(posedge clk); #1;
    bus.clear_fail_i = 1'b1;
    @(posedge clk); #1;
    bus.clear_fail_i = 1'b0;
    check("clear fail_o", bus.fail_o, 0);
    check("clear fail_code", bus.fail_code_o, 0);
    check("clear en", bus.trng_en_o, 1);
  endtask

  initial begin
    bus.trng_data_i  = '0;
    bus.trng_valid_i = 1'b0;
    bus.word_ready_i = 1'b1;
    bus.clear_fail_i = 1'b0;

    tbl[0] = '{build(0), 1'b1, 2'b00, 16'd1, "distinct_pass"};
    tbl[1] = '{build(1), 1'b0, 2'b01, 16'd1, "rep_a5"};
    tbl[2] = '{build(2), 1'b0, 2'b11, 16'd1, "all_zero"};
    tbl[3] = '{build(3), 1'b0, 2'b10, 16'd1, "low_ones"};

    #12;
    check("rst en", bus.trng_en_o, 1);
    check("rst valid", bus.word_valid_o, 0);
    check("rst word", bus.word_o, 0);
    check("rst fail", bus.fail_o, 0);
    check("rst code", bus.fail_code_o, 0);
    check("rst cnt", bus.block_cnt_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      send_block(tbl[i].blk, tbl[i].pass);
      wait_result(tbl[i].pass, tbl[i].code, tbl[i].cnt, tbl[i].name);
      if (tbl[i].pass) drain(1'b0);
      else clear_seq();
    end

    // Stalled drain with ready pattern 1,0,0,1
    send_block(build(4), 1'b1);
    wait_result(1'b1, 2'b00, 16'd2, "stall_block");
    drain(1'b1);

    // Word 0 repeats the previous block's last word
    send_block(build(5), 1'b0);
    wait_result(1'b0, 2'b01, 16'd2, "rep_cross_block");
    clear_seq();

    // Reset in the middle of DRAIN
    send_block(build(4), 1'b1);
    wait_result(1'b1, 2'b00, 16'd3, "pre_reset");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst valid", bus.word_valid_o, 0);
    check("mid_rst cnt", bus.block_cnt_o, 0);
    check("mid_rst en", bus.trng_en_o, 1);
    check("mid_rst word", bus.word_o, 0);
    check("mid_rst xfers", xfer_cnt, 3);
    exp_q.delete();
    xfer_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Same cross-block pattern now passes: previous word was forgotten by reset
    send_block(build(5), 1'b1);
    wait_result(1'b1, 2'b00, 16'd1, "post_reset");
    drain(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
